// File: rtl/code_correlator.sv
`default_nettype none
// ============================================================================
//  Module   : code_correlator
//  Purpose  : Correlates baseband samples against an upsampled C/A code over
//             one full code period (phases 0..16799), dumps the sum to a
//             result register with a valid/ack handshake, a sticky overrun
//             flag and a completed-period counter.
//  Options  : CODE_CORRELATOR_SATURATE_EN - when defined, every accumulator
//             addition clamps to the signed ACC_WIDTH range; otherwise wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module code_correlator #(
    parameter int SAMPLE_WIDTH = 3,
    parameter int ACC_WIDTH    = 18
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic                           code_bit,
    input  logic [14:0]                    code_shift,
    input  logic                           seeking,
    output logic signed [ACC_WIDTH-1:0]    result,
    output logic                           result_valid,
    input  logic                           result_ack,
    output logic                           overrun,
    output logic [15:0]                    period_count
);

    localparam logic [14:0] c_last_phase = 15'd16799;
    localparam logic [0:0]  c_idle       = 1'b0;
    localparam logic [0:0]  c_accum      = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   result_q, result_d;
    logic                          result_valid_q, result_valid_d;
    logic                          overrun_q, overrun_d;
    logic [15:0]                   period_count_q, period_count_d;

    logic signed [SAMPLE_WIDTH:0]  w_sample_ext;
    logic signed [SAMPLE_WIDTH:0]  w_product;
    logic signed [ACC_WIDTH-1:0]   w_product_ext;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic                          w_start;
    logic                          w_dump_phase;

    // Signed product one bit wider than the sample so that negating the most
    // negative input cannot overflow, then sign-extended to accumulator width.
    always_comb begin
        w_sample_ext  = {sample[SAMPLE_WIDTH-1], sample};
        w_product     = code_bit ? w_sample_ext : -w_sample_ext;
        w_product_ext = {{(ACC_WIDTH-SAMPLE_WIDTH-1){w_product[SAMPLE_WIDTH]}}, w_product};
        w_start       = enable && (code_shift == 15'd0);
        w_dump_phase  = (code_shift == c_last_phase);
    end

`ifdef CODE_CORRELATOR_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_sum_wide;

    // Accumulator addition with one guard bit; clamp when the guard bit and
    // the result sign disagree.
    always_comb begin
        w_sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {w_product_ext[ACC_WIDTH-1], w_product_ext};
        if (w_sum_wide[ACC_WIDTH] != w_sum_wide[ACC_WIDTH-1]) begin
            w_sum = w_sum_wide[ACC_WIDTH] ? c_acc_min : c_acc_max;
        end else begin
            w_sum = w_sum_wide[ACC_WIDTH-1:0];
        end
    end
`else
    // Accumulator addition wrapping modulo 2^ACC_WIDTH.
    always_comb begin
        w_sum = acc_q + w_product_ext;
    end
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= c_idle;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            period_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            period_count_q <= period_count_d;
        end
    end

    // Next state: a seek always aborts to IDLE; IDLE leaves on an enabled phase-0 sample.
    always_comb begin
        state_d = state_q;
        if (seeking) begin
            state_d = c_idle;
        end else if ((state_q == c_idle) && w_start) begin
            state_d = c_accum;
        end
    end

    // Accumulate, dump and handshake bookkeeping.
    always_comb begin
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        period_count_d = period_count_q;

        // A consumer ack retires the result; a dump in the same cycle re-asserts valid below.
        if (result_ack && result_valid_q) begin
            result_valid_d = 1'b0;
        end

        if (seeking) begin
            acc_d = '0;
        end else if (state_q == c_idle) begin
            // The phase-0 sample that opens the period is its first term.
            if (w_start) begin
                acc_d = w_product_ext;
            end
        end else if (enable) begin
            if (w_dump_phase) begin
                result_d       = w_sum;
                acc_d          = '0;
                result_valid_d = 1'b1;
                period_count_d = period_count_q + 16'd1;
                if (result_valid_q && !result_ack) begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d = w_sum;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        result       = result_q;
        result_valid = result_valid_q;
        overrun      = overrun_q;
        period_count = period_count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_code_correlator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_code_correlator
//  Purpose  : Directed self-checking bench for code_correlator. A second
//             instance with ACC_WIDTH=16 shares the stimulus to exercise the
//             overflow behaviour selected by CODE_CORRELATOR_SATURATE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_code_correlator;

    logic              clk;
    logic              reset;
    logic              enable;
    logic signed [2:0] sample;
    logic              code_bit;
    logic [14:0]       code_shift;
    logic              seeking;
    logic              result_ack;

    logic signed [17:0] result;
    logic               result_valid;
    logic               overrun;
    logic [15:0]        period_count;

    logic signed [15:0] result16;
    logic               result_valid16;
    logic               overrun16;
    logic [15:0]        period_count16;

    int errors = 0;
    int checks = 0;

    code_correlator #(.SAMPLE_WIDTH(3), .ACC_WIDTH(18)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample       (sample),
        .code_bit     (code_bit),
        .code_shift   (code_shift),
        .seeking      (seeking),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .overrun      (overrun),
        .period_count (period_count)
    );

    code_correlator #(.SAMPLE_WIDTH(3), .ACC_WIDTH(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample       (sample),
        .code_bit     (code_bit),
        .code_shift   (code_shift),
        .seeking      (seeking),
        .result       (result16),
        .result_valid (result_valid16),
        .result_ack   (result_ack),
        .overrun      (overrun16),
        .period_count (period_count16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic en, input int ph, input int smp, input logic cb,
                         input logic sk, input logic ack);
        enable     = en;
        code_shift = 15'(ph);
        sample     = 3'(smp);
        code_bit   = cb;
        seeking    = sk;
        result_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // Enabled samples with a constant value over a phase range.
    task automatic run_const(input int from_ph, input int to_ph, input int smp, input logic cb);
        for (int p = from_ph; p <= to_ph; p++) begin
            drive(1'b1, p, smp, cb, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 0, 1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16799, 1, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        checks++; if (result !== 18'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (period_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", period_count); end
    endtask

    // Stream starts mid-code: nothing counts until phase 0, then +1 for a full period.
    task automatic test_basic;
        run_const(16000, 16799, 1, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL idle_no_dump_valid: got %b expected 0", result_valid); end
        checks++; if (period_count !== 16'd0) begin errors++; $display("FAIL idle_no_dump_count: got %0d expected 0", period_count); end
        run_const(0, 16798, 1, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_dump_valid: got %b expected 0", result_valid); end
        drive(1'b1, 16799, 1, 1'b1, 1'b0, 1'b0);
        checks++; if (result !== 18'd16800) begin errors++; $display("FAIL basic_result: got %0d expected 16800", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
        checks++; if (period_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", period_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    endtask

    // Gapped enable with garbage on the idle cycles; ack lands on the dump cycle.
    // Sum: 10000*(+3) + 6800*(-3) = 9600.
    task automatic test_enable_gaps_ack_on_dump;
        for (int p = 0; p <= 16798; p++) begin
            drive(1'b1, p, 3, (p < 10000), 1'b0, 1'b0);
            if (p < 2000 || p == 16798) drive(1'b0, p, -4, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (result !== 18'd16800) begin errors++; $display("FAIL gaps_old_result_held: got %0d expected 16800", result); end
        drive(1'b1, 16799, 3, 1'b0, 1'b0, 1'b1);
        checks++; if (result !== 18'd9600) begin errors++; $display("FAIL gaps_result: got %0d expected 9600", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL ackdump_valid: got %b expected 1", result_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ackdump_overrun: got %b expected 0", overrun); end
        checks++; if (period_count !== 16'd2) begin errors++; $display("FAIL gaps_count: got %0d expected 2", period_count); end
        drive(1'b0, 16799, -4, 1'b1, 1'b0, 1'b0);
        checks++; if (result !== 18'd9600) begin errors++; $display("FAIL gaps_result_hold: got %0d expected 9600", result); end
    endtask

    // Seek aborts at phase 8000; then a fresh -4 x (-1) period dumps over an unacked result.
    task automatic test_seek_then_overrun;
        logic signed [15:0] exp16;
`ifdef CODE_CORRELATOR_SATURATE_EN
        exp16 = 16'sd32767;
`else
        exp16 = 16'sd1664;
`endif
        run_const(0, 7999, 1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 8000, 1, 1'b1, 1'b1, 1'b0);
        run_const(8001, 8004, 1, 1'b1);
        checks++; if (result !== 18'd9600) begin errors++; $display("FAIL seek_result_held: got %0d expected 9600", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL seek_valid_held: got %b expected 1", result_valid); end
        checks++; if (period_count !== 16'd2) begin errors++; $display("FAIL seek_count_held: got %0d expected 2", period_count); end
        run_const(0, 16798, -4, 1'b0);
        drive(1'b1, 16799, -4, 1'b0, 1'b0, 1'b0);
        checks++; if (result !== 18'd67200) begin errors++; $display("FAIL neg4_result: got %0d expected 67200", result); end
        checks++; if (result16 !== exp16) begin errors++; $display("FAIL neg4_result_w16: got %0d expected %0d", result16, exp16); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (overrun16 !== 1'b1 || result_valid16 !== 1'b1) begin errors++; $display("FAIL w16_flags: got ovr=%b valid=%b expected 1 1", overrun16, result_valid16); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", result_valid); end
        checks++; if (period_count !== 16'd3 || period_count16 !== 16'd3) begin errors++; $display("FAIL overrun_count: got %0d/%0d expected 3", period_count, period_count16); end
    endtask

    task automatic test_ack;
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_clears_valid: got %b expected 0", result_valid); end
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_ignored_valid: got %b expected 0", result_valid); end
        checks++; if (result !== 18'd67200) begin errors++; $display("FAIL ack_result_kept: got %0d expected 67200", result); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    // Reset mid-period with busy inputs, then a late-phase stream must not dump.
    task automatic test_reset_mid_period;
        run_const(0, 99, 1, 1'b1);
        reset = 1'b1;
        drive(1'b1, 16799, 1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16799, 1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (overrun !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags: got ovr=%b valid=%b expected 0 0", overrun, result_valid); end
        checks++; if (result !== 18'd0 || period_count !== 16'd0) begin errors++; $display("FAIL midreset_regs: got result=%0d count=%0d expected 0 0", result, period_count); end
        run_const(16790, 16799, 1, 1'b1);
        checks++; if (result_valid !== 1'b0 || period_count !== 16'd0) begin errors++; $display("FAIL midreset_no_dump: got valid=%b count=%0d expected 0 0", result_valid, period_count); end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        sample     = 3'sd0;
        code_bit   = 1'b0;
        code_shift = 15'd0;
        seeking    = 1'b0;
        result_ack = 1'b0;
        test_reset();
        test_basic();
        test_enable_gaps_ack_on_dump();
        test_seek_then_overrun();
        test_ack();
        test_reset_mid_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
